// File: rtl/mem_pkg.sv
// Shared definitions for the load/store unit: load-op one-hot indices,
// access-size encodings, FSM states and small decode helpers.
package mem_pkg;

  localparam int OP_LD  = 0;
  localparam int OP_LW  = 1;
  localparam int OP_LH  = 2;
  localparam int OP_LB  = 3;
  localparam int OP_LWU = 4;
  localparam int OP_LHU = 5;
  localparam int OP_LBU = 6;

  localparam logic [3:0] SZ_B = 4'd1;
  localparam logic [3:0] SZ_H = 4'd2;
  localparam logic [3:0] SZ_W = 4'd4;
  localparam logic [3:0] SZ_D = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RSP,
    S_DONE
  } state_t;

  function automatic logic is_onehot7(input logic [6:0] v);
    return (v != 7'd0) && ((v & (v - 7'd1)) == 7'd0);
  endfunction

  // Byte-enable pattern for an access of the given size at offset 0.
  function automatic logic [7:0] size_mask(input logic [3:0] len);
    case (len)
      SZ_B:    return 8'h01;
      SZ_H:    return 8'h03;
      SZ_W:    return 8'h0F;
      SZ_D:    return 8'hFF;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Moves the addressed bytes of a returned doubleword down to bit 0 and
// sign- or zero-extends them according to the one-hot load type.
module lsu_load_align
  import mem_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  off,
  input  logic [6:0]  op,
  output logic [63:0] wb_data
);

  logic [63:0] shifted;

  always_comb begin
    shifted = rdata >> {off, 3'b000};
    wb_data = shifted;
    if (op[OP_LB])       wb_data = {{56{shifted[7]}},  shifted[7:0]};
    else if (op[OP_LH])  wb_data = {{48{shifted[15]}}, shifted[15:0]};
    else if (op[OP_LW])  wb_data = {{32{shifted[31]}}, shifted[31:0]};
    else if (op[OP_LBU]) wb_data = {56'd0, shifted[7:0]};
    else if (op[OP_LHU]) wb_data = {48'd0, shifted[15:0]};
    else if (op[OP_LWU]) wb_data = {32'd0, shifted[31:0]};
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: validates a decoded access, runs one request/response
// transaction on the data-memory port and returns aligned load data.
module lsu_mem_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_mem_en,
  input  logic              wr_mem_en,
  input  logic [6:0]        rd_mem_op,
  input  logic [3:0]        wr_rd_mem_len,
  input  logic [4:0]        rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [7:0]        mem_req_wstrb,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_rdata,
  input  logic              mem_rsp_err,
  output logic              stall,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [63:0]       wb_data,
  output logic              fault
);

  state_t      state;
  logic [2:0]  off_q;
  logic [6:0]  op_q;
  logic [4:0]  rd_q;
  logic        is_load_q;

  logic        load_start;
  logic        store_start;
  logic        size_ok;
  logic        misaligned;
  logic        start_err;
  logic [63:0] align_data;

  assign load_start  = rd_mem_en | (|rd_mem_op);
  assign store_start = wr_mem_en;

  // Start-time validity: size, conflicting enables, op encoding, alignment.
  always_comb begin
    size_ok    = 1'b1;
    misaligned = 1'b0;
    case (wr_rd_mem_len)
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = addr[0];
      SZ_W:    misaligned = |addr[1:0];
      SZ_D:    misaligned = |addr[2:0];
      default: size_ok = 1'b0;
    endcase
    start_err = (load_start & store_start) | ~size_ok | misaligned |
                (load_start & ~is_onehot7(rd_mem_op));
  end

  assign stall = (state == S_IDLE) ? (load_start | store_start)
                                   : ((state == S_REQ) | (state == S_RSP));

  lsu_load_align u_align (
    .rdata   (mem_rsp_rdata),
    .off     (off_q),
    .op      (op_q),
    .wb_data (align_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      off_q         <= '0;
      op_q          <= '0;
      rd_q          <= '0;
      is_load_q     <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_we    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wstrb <= '0;
      mem_req_wdata <= '0;
      wb_valid      <= 1'b0;
      wb_rd         <= '0;
      wb_data       <= '0;
      fault         <= 1'b0;
    end else begin
      fault    <= 1'b0;
      wb_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (load_start | store_start) begin
            if (start_err) begin
              fault <= 1'b1;
            end else begin
              state         <= S_REQ;
              off_q         <= addr[2:0];
              op_q          <= rd_mem_op;
              rd_q          <= rd;
              is_load_q     <= load_start;
              mem_req_valid <= 1'b1;
              mem_req_we    <= ~load_start;
              mem_req_addr  <= {addr[ADDR_W-1:3], 3'b000};
              mem_req_wstrb <= load_start ? 8'h00 : (size_mask(wr_rd_mem_len) << addr[2:0]);
              mem_req_wdata <= load_start ? '0 : (st_data << {addr[2:0], 3'b000});
            end
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= S_RSP;
          end
        end
        // A bus error suppresses the write-back and is reported as a fault instead.
        S_RSP: begin
          if (mem_rsp_valid) begin
            state <= S_DONE;
            if (mem_rsp_err) begin
              fault <= 1'b1;
            end else if (is_load_q) begin
              wb_valid <= 1'b1;
              wb_rd    <= rd_q;
              wb_data  <= align_data;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: directed cases plus randomized accesses
// checked against a byte-level model of requests, write-backs and faults.
module tb_lsu_mem_ctrl;

  typedef struct {
    int          ready_dly;
    int          rsp_dly;
    logic [63:0] rdata;
    logic        err;
  } plan_t;

  typedef struct {
    logic [63:0] addr;
    logic        we;
    logic [7:0]  wstrb;
    logic [63:0] wdata;
  } req_t;

  typedef struct {
    logic        is_fault;
    logic [4:0]  rd;
    logic [63:0] data;
    int          cyc;
  } out_t;

  logic        clk;
  logic        rst_n;
  logic        rd_mem_en;
  logic        wr_mem_en;
  logic [6:0]  rd_mem_op;
  logic [3:0]  wr_rd_mem_len;
  logic [4:0]  rd;
  logic [63:0] addr;
  logic [63:0] st_data;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [63:0] mem_req_addr;
  logic [7:0]  mem_req_wstrb;
  logic [63:0] mem_req_wdata;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_rdata;
  logic        mem_rsp_err;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        fault;

  plan_t plan_q[$];
  req_t  exp_req_q[$];
  out_t  out_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Bytes and signedness per one-hot op index {ld,lw,lh,lb,lwu,lhu,lbu}.
  int op_bytes[7] = '{8, 4, 2, 1, 4, 2, 1};
  bit op_sgn[7]   = '{0, 1, 1, 1, 0, 0, 0};

  lsu_mem_ctrl #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rd_mem_en     (rd_mem_en),
    .wr_mem_en     (wr_mem_en),
    .rd_mem_op     (rd_mem_op),
    .wr_rd_mem_len (wr_rd_mem_len),
    .rd            (rd),
    .addr          (addr),
    .st_data       (st_data),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_we    (mem_req_we),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wstrb (mem_req_wstrb),
    .mem_req_wdata (mem_req_wdata),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_rdata (mem_rsp_rdata),
    .mem_rsp_err   (mem_rsp_err),
    .stall         (stall),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .fault         (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: time limit reached, failures so far %0d", n_fail);
    $fatal(1, "[TB] simulation time limit");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] load_model(input logic [63:0] rdata, input int off,
                                             input int nbytes, input bit sgn);
    logic [63:0] v;
    logic [63:0] m;
    v = rdata >> (8 * off);
    if (nbytes == 8) return v;
    m = (64'd1 << (8 * nbytes)) - 64'd1;
    v = v & m;
    if (sgn && v[8*nbytes-1]) v = v | ~m;
    return v;
  endfunction

  // Memory side: random ready delay, random response latency, idle noise.
  initial begin : responder
    plan_t p;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = '0;
    mem_rsp_err   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && mem_req_valid && plan_q.size() > 0) begin
        p = plan_q.pop_front();
        mem_rsp_valid = 1'b0;
        mem_rsp_err   = 1'b0;
        repeat (p.ready_dly) @(negedge clk);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        repeat (p.rsp_dly) @(negedge clk);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = p.rdata;
        mem_rsp_err   = p.err;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        mem_rsp_err   = 1'b0;
      end else begin
        mem_rsp_valid = ($urandom_range(0, 3) == 0);
        mem_rsp_err   = ($urandom_range(0, 1) == 0);
        mem_rsp_rdata = {$urandom, $urandom};
      end
    end
  end

  // Scoreboard monitor: compares requests and write-back/fault events.
  initial begin : monitor
    req_t e;
    out_t o;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) continue;
      if (mem_req_valid) begin
        if (exp_req_q.size() == 0) begin
          checkOutput("unexpected_req_valid", mem_req_valid, 0);
        end else begin
          e = exp_req_q[0];
          checkOutput("req_addr",  mem_req_addr,  e.addr);
          checkOutput("req_we",    mem_req_we,    e.we);
          checkOutput("req_wstrb", mem_req_wstrb, e.wstrb);
          checkOutput("req_wdata", mem_req_wdata, e.wdata);
          if (mem_req_ready) void'(exp_req_q.pop_front());
        end
      end
      if (wb_valid || fault) begin
        if (out_q.size() == 0) begin
          checkOutput("unexpected_wb_valid", wb_valid, 0);
          checkOutput("unexpected_fault", fault, 0);
        end else begin
          o = out_q.pop_front();
          checkOutput("fault", fault, o.is_fault);
          checkOutput("wb_valid", wb_valid, !o.is_fault);
          if (!o.is_fault) begin
            checkOutput("wb_rd", wb_rd, o.rd);
            checkOutput("wb_data", wb_data, o.data);
          end
          checkOutput("event_cycle", cyc, o.cyc);
        end
      end
    end
  end

  task automatic applyStimulus(input logic ren, input logic wen, input logic [6:0] op,
                               input logic [3:0] len, input logic [4:0] rdi,
                               input logic [63:0] a, input logic [63:0] sd,
                               input int d, input int r, input logic [63:0] rdat,
                               input logic berr, input int rst_at);
    bit   is_ld, is_st, bad, len_ok;
    int   off, k, c0, waited;
    req_t q;
    out_t o;
    plan_t p;
    is_ld  = ren || (op != 7'd0);
    is_st  = wen;
    len_ok = (len == 4'd1) || (len == 4'd2) || (len == 4'd4) || (len == 4'd8);
    off    = int'(a[2:0]);
    bad    = (is_ld && is_st) || !len_ok || (is_ld && $countones(op) != 1) ||
             (len_ok && (a % 64'(len)) != 64'd0);
    k = 0;
    for (int i = 0; i < 7; i++) if (op[i]) k = i;

    @(negedge clk);
    c0 = cyc;
    if (bad) begin
      o.is_fault = 1'b1; o.rd = '0; o.data = '0; o.cyc = c0 + 1;
      out_q.push_back(o);
    end else begin
      q.addr  = a & ~64'h7;
      q.we    = !is_ld;
      q.wstrb = is_ld ? 8'h00 : 8'(((1 << len) - 1) << off);
      q.wdata = is_ld ? 64'd0 : (sd << (8 * off));
      exp_req_q.push_back(q);
      p.ready_dly = d; p.rsp_dly = r; p.rdata = rdat; p.err = berr;
      plan_q.push_back(p);
      if (rst_at < 0) begin
        o.cyc = c0 + 3 + d + r;
        if (berr) begin
          o.is_fault = 1'b1; o.rd = '0; o.data = '0;
          out_q.push_back(o);
        end else if (is_ld) begin
          o.is_fault = 1'b0; o.rd = rdi;
          o.data = load_model(rdat, off, op_bytes[k], op_sgn[k]);
          out_q.push_back(o);
        end
      end
    end

    rd_mem_en = ren; wr_mem_en = wen; rd_mem_op = op; wr_rd_mem_len = len;
    rd = rdi; addr = a; st_data = sd;
    #1;
    checkOutput("stall_at_start", stall, 1);
    @(negedge clk);
    rd_mem_en = 1'b0; wr_mem_en = 1'b0; rd_mem_op = '0; wr_rd_mem_len = '0;
    rd = '0; addr = {$urandom, $urandom}; st_data = {$urandom, $urandom};

    if (rst_at >= 0) begin
      repeat (rst_at - 1) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("rst_req_valid", mem_req_valid, 0);
      checkOutput("rst_req_wstrb", mem_req_wstrb, 0);
      checkOutput("rst_req_addr",  mem_req_addr,  0);
      checkOutput("rst_stall",     stall,         0);
      checkOutput("rst_wb_valid",  wb_valid,      0);
      checkOutput("rst_wb_data",   wb_data,       0);
      checkOutput("rst_fault",     fault,         0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
    end else begin
      waited = 0;
      #1;
      while (stall && waited < 64) begin
        @(negedge clk);
        #1;
        waited++;
      end
      checkOutput("stall_release_cycle", cyc, bad ? c0 + 1 : c0 + 3 + d + r);
      repeat (2) @(negedge clk);
    end
  endtask

  initial begin : driver
    logic [63:0] rdat;
    logic [63:0] a;
    logic [6:0]  op;
    logic [3:0]  len;
    logic [3:0]  bad_lens[8] = '{4'd0, 4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd12, 4'd15};
    int          k, sel, kind;
    int          mis_ops[5] = '{0, 1, 2, 4, 5};

    rst_n = 1'b0;
    rd_mem_en = 1'b0; wr_mem_en = 1'b0; rd_mem_op = '0; wr_rd_mem_len = '0;
    rd = '0; addr = '0; st_data = '0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_req_valid", mem_req_valid, 0);
    checkOutput("reset_req_we",    mem_req_we,    0);
    checkOutput("reset_req_addr",  mem_req_addr,  0);
    checkOutput("reset_req_wstrb", mem_req_wstrb, 0);
    checkOutput("reset_req_wdata", mem_req_wdata, 0);
    checkOutput("reset_stall",     stall,         0);
    checkOutput("reset_wb_valid",  wb_valid,      0);
    checkOutput("reset_wb_rd",     wb_rd,         0);
    checkOutput("reset_wb_data",   wb_data,       0);
    checkOutput("reset_fault",     fault,         0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] directed accesses");
    rdat = 64'h0123456789ABCDEF;
    applyStimulus(1, 0, 7'b0001000, 4'd1, 5'd5,  64'h1003, 0, 0, 0, rdat, 0, -1);
    applyStimulus(1, 0, 7'b1000000, 4'd1, 5'd6,  64'h1003, 0, 0, 0, rdat, 0, -1);
    applyStimulus(1, 0, 7'b0000010, 4'd4, 5'd7,  64'h1004, 0, 0, 0, rdat, 0, -1);
    applyStimulus(1, 0, 7'b0000100, 4'd2, 5'd8,  64'h1002, 0, 0, 0, rdat, 0, -1);
    applyStimulus(0, 1, 7'b0000000, 4'd4, 5'd0,  64'h2004, 64'hDEADBEEF, 0, 0, rdat, 0, -1);
    applyStimulus(1, 0, 7'b0000010, 4'd4, 5'd9,  64'h2002, 0, 0, 0, rdat, 0, -1);
    applyStimulus(0, 1, 7'b0000000, 4'd3, 5'd0,  64'h2008, 64'h55, 0, 0, rdat, 0, -1);
    #1;
    checkOutput("stall_after_faults", stall, 0);
    applyStimulus(1, 0, 7'b0000001, 4'd8, 5'd10, 64'h4000, 0, 3, 1, rdat, 1, -1);
    applyStimulus(1, 0, 7'b0000001, 4'd8, 5'd11, 64'h2800, 0, 0, 4, rdat, 0, 2);
    applyStimulus(1, 0, 7'b0000001, 4'd8, 5'd12, 64'h3000, 0, 0, 0, 64'hA5A5_0F0F_1234_8765, 0, -1);

    $display("[TB] randomized accesses");
    for (int n = 0; n < 160; n++) begin
      k    = $urandom_range(0, 6);
      sel  = $urandom_range(0, 9);
      rdat = {$urandom, $urandom};
      a    = {$urandom, $urandom};
      if (sel < 5) begin
        op  = 7'(1 << k);
        len = 4'(op_bytes[k]);
        a   = a & ~(64'(len) - 64'd1);
        applyStimulus(1'($urandom_range(0, 1)), 0, op, len, 5'($urandom), a, 0,
                      $urandom_range(0, 3), $urandom_range(0, 3), rdat,
                      ($urandom_range(0, 7) == 0), -1);
      end else if (sel < 8) begin
        len = 4'(1 << $urandom_range(0, 3));
        a   = a & ~(64'(len) - 64'd1);
        applyStimulus(0, 1, 0, len, 5'($urandom), a, {$urandom, $urandom},
                      $urandom_range(0, 3), $urandom_range(0, 3), rdat,
                      ($urandom_range(0, 7) == 0), -1);
      end else begin
        kind = $urandom_range(0, 3);
        case (kind)
          0: applyStimulus(1, 1, 7'(1 << k), 4'(op_bytes[k]), 5'($urandom), a & ~64'h7,
                           {$urandom, $urandom}, 0, 0, rdat, 0, -1);
          1: applyStimulus(0, 1, 0, bad_lens[$urandom_range(0, 7)], 5'($urandom), a & ~64'h7,
                           {$urandom, $urandom}, 0, 0, rdat, 0, -1);
          2: applyStimulus(1'($urandom_range(0, 1)), 0, 7'((1 << k) | (1 << ((k + 3) % 7))),
                           4'd1, 5'($urandom), a, 0, 0, 0, rdat, 0, -1);
          default: begin
            k = mis_ops[$urandom_range(0, 4)];
            applyStimulus(1, 0, 7'(1 << k), 4'(op_bytes[k]), 5'($urandom),
                          (a & ~64'h7) | 64'h1, 0, 0, 0, rdat, 0, -1);
          end
        endcase
      end
    end

    repeat (5) @(negedge clk);
    checkOutput("pending_requests", exp_req_q.size(), 0);
    checkOutput("pending_outputs",  out_q.size(),     0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
